instruction_packer: RTL and testbench

Command-side producer for the pixel pipeline's 32-bit instruction port. It assembles a byte stream from the host UART receiver into 32-bit instruction words and buffers them in a small FIFO. Each word is issued as a single-cycle o_instruction_ready pulse, with o_instruction valid in that same cycle. It sits between the UART RX block and the pixel generator, and can hold issue off, for example during active video.

---
 rtl/instruction_packer.sv | 178 +++++++++++++++++
 tb/tb_instruction_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_packer.sv
// instruction_packer: packs UART bytes (little-endian) into 32-bit words, buffers them in a FIFO and issues one per strobe.
// Optional macro INSTRUCTION_PACKER_CHECKSUM_EN adds a trailing XOR check byte per word. Rev 1.0
`default_nettype none

module instruction_packer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_hold,
  input  logic                          i_clear_errors,
  output logic [31:0]                   o_instruction,
  output logic                          o_instruction_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic                          o_frame_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    COLLECT = 2'd1
  } state_t;

  state_t             state;
  logic [1:0]         count;
  logic [TMR_W-1:0]   timer;
  logic [31:0]        word_buf;
  logic               frame_error;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [31:0]        instruction;
  logic               instruction_ready;
  logic               overflow;

  logic               push_req;
  logic [31:0]        push_word;
  logic               pop;
  logic               full;
  logic               do_push;

  assign full    = (level == LVL_FULL);
  assign pop     = (level != '0) && !i_hold;
  assign do_push = push_req && (!full || pop);

`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = word_buf[7:0] ^ word_buf[15:8] ^ word_buf[23:16] ^ word_buf[31:24];

  always_comb begin
    push_word = word_buf;
    push_req  = (state == CHECK) && i_rx_valid && (i_rx_data == checksum);
  end
`else
  // Top byte of word_buf is always zero while collecting, so OR-ing in the final byte completes the word.
  always_comb begin
    push_word = word_buf | {i_rx_data, 24'h0};
    push_req  = (state == COLLECT) && i_rx_valid && (count == 2'd3);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= '0;
      timer       <= '0;
      word_buf    <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            word_buf <= {24'h0, i_rx_data};
            count    <= 2'd1;
            timer    <= '0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (i_rx_valid) begin
            word_buf[{count, 3'b000} +: 8] <= i_rx_data;
            count <= count + 2'd1;
            timer <= '0;
            if (count == 2'd3) begin
`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
              state <= CHECK;
`else
              state <= IDLE;
`endif
            end
          end else if (timer == TMR_LAST) begin
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
            frame_error <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
        CHECK: begin
          if (i_rx_valid) begin
            frame_error <= (i_rx_data != checksum);
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
          end else if (timer == TMR_LAST) begin
            state       <= IDLE;
            count       <= '0;
            timer       <= '0;
            frame_error <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      instruction       <= '0;
      instruction_ready <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      if (pop) begin
        instruction       <= mem[rd_ptr];
        instruction_ready <= 1'b1;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end else begin
        instruction       <= '0;
        instruction_ready <= 1'b0;
      end
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push_req && !do_push) overflow <= 1'b1;
      else if (i_clear_errors)  overflow <= 1'b0;
    end
  end

  assign o_instruction       = instruction;
  assign o_instruction_ready = instruction_ready;
  assign o_fifo_level        = level;
  assign o_overflow          = overflow;
  assign o_frame_error       = frame_error;

endmodule

`default_nettype wire

// File: tb/tb_instruction_packer.sv
// tb_instruction_packer: table vectors, directed corner sequences and random traffic against a queue-based model.
`default_nettype none

module tb_instruction_packer;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;
`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        hold = 1'b0;
  logic        clear_errors = 1'b0;
  logic [31:0] instruction;
  logic        instruction_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;
  logic        frame_error;

  instruction_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_hold(hold), .i_clear_errors(clear_errors), .o_instruction(instruction),
    .o_instruction_ready(instruction_ready), .o_fifo_level(fifo_level),
    .o_overflow(overflow), .o_frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: partial frame bytes, idle gap, queued words, expected registered outputs.
  logic [7:0]  part[$];
  int          gap;
  logic [31:0] mq[$];
  logic        m_ovf, m_rdy, m_ferr;
  logic [31:0] m_instr;

  logic [31:0] issued[$];
  int          ferr_count;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    part.delete(); mq.delete();
    gap = 0; m_ovf = 0; m_rdy = 0; m_ferr = 0; m_instr = '0;
  endfunction

  function automatic void model_step(logic v, logic [7:0] d, logic h, logic c);
    logic        complete = 0;
    logic [31:0] word = '0;
    m_ferr = 0;
    if (v) begin
      part.push_back(d);
      gap = 0;
      if (part.size() == NB) begin
        word = {part[3], part[2], part[1], part[0]};
        complete = 1;
        if (NB == 5 && part[4] != (part[0] ^ part[1] ^ part[2] ^ part[3])) begin
          complete = 0;
          m_ferr = 1;
        end
        part.delete();
      end
    end else if (part.size() > 0) begin
      gap++;
      if (gap == TMO) begin
        part.delete();
        gap = 0;
        m_ferr = 1;
      end
    end
    if (mq.size() > 0 && !h) begin
      m_instr = mq.pop_front();
      m_rdy = 1;
    end else begin
      m_instr = '0;
      m_rdy = 0;
    end
    if (c) m_ovf = 0;
    if (complete) begin
      if (mq.size() < DEPTH) mq.push_back(word);
      else m_ovf = 1;
    end
  endfunction

  task automatic cycle(input logic v, input logic [7:0] d, input logic h, input logic c);
    rx_valid = v; rx_data = d; hold = h; clear_errors = c;
    model_step(v, d, h, c);
    @(posedge clk); #1;
    chk("instr", instruction, m_instr);
    chk("ready", {31'h0, instruction_ready}, {31'h0, m_rdy});
    chk("level", {28'h0, fifo_level}, mq.size());
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    chk("frame_error", {31'h0, frame_error}, {31'h0, m_ferr});
    if (instruction_ready) issued.push_back(instruction);
    if (frame_error) ferr_count++;
    rx_valid = 0; clear_errors = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic h);
    for (int i = 0; i < 4; i++) cycle(1'b1, w[8*i +: 8], h, 1'b0);
    if (NB == 5) cycle(1'b1, w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], h, 1'b0);
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h0, h, 1'b0);
  endtask

  task automatic assert_reset();
    rst_n = 0; #1;
    chk("rst_instr", instruction, 32'h0);
    chk("rst_ready", {31'h0, instruction_ready}, 32'h0);
    chk("rst_level", {28'h0, fifo_level}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_frame_error", {31'h0, frame_error}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] words[9];
  logic [31:0] w;

  initial begin
    tbl[0] = '{8'h07, 8'h2A, 8'h05, 8'h00, 32'h00052A07};
    tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'h80, 32'h800000FF};
    tbl[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    tbl[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
    model_reset();
    ferr_count = 0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_level", {28'h0, fifo_level}, 32'h0);
    chk("reset_ready", {31'h0, instruction_ready}, 32'h0);

    // Table vectors with latency: strobe appears one idle cycle after the final byte's edge.
    for (int i = 0; i < 5; i++) begin
      issued.delete();
      cycle(1'b1, tbl[i].b0, 1'b0, 1'b0);
      cycle(1'b1, tbl[i].b1, 1'b0, 1'b0);
      cycle(1'b1, tbl[i].b2, 1'b0, 1'b0);
      cycle(1'b1, tbl[i].b3, 1'b0, 1'b0);
      if (NB == 5) cycle(1'b1, tbl[i].b0 ^ tbl[i].b1 ^ tbl[i].b2 ^ tbl[i].b3, 1'b0, 1'b0);
      chk("lat_not_early", {31'h0, instruction_ready}, 32'h0);
      idle(1, 1'b0);
      chk("lat_ready", {31'h0, instruction_ready}, 32'h1);
      chk("lat_word", instruction, tbl[i].exp);
      idle(1, 1'b0);
      chk("lat_single_pulse", {31'h0, instruction_ready}, 32'h0);
      chk("lat_level_zero", {28'h0, fifo_level}, 32'h0);
    end

    // Fill under hold, overflow on the 9th word, then drain back-to-back.
    issued.delete();
    for (int i = 0; i < 9; i++) begin
      words[i] = 32'hC0DE0000 + 32'(i * 32'h111);
      send_word(words[i], 1'b1);
    end
    chk("full_level", {28'h0, fifo_level}, 32'd8);
    chk("full_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      idle(1, 1'b0);
      chk("drain_ready", {31'h0, instruction_ready}, 32'h1);
      chk("drain_word", instruction, words[i]);
    end
    idle(1, 1'b0);
    chk("drain_no_ninth", {31'h0, instruction_ready}, 32'h0);
    cycle(1'b0, 8'h0, 1'b0, 1'b1);
    chk("overflow_cleared", {31'h0, overflow}, 32'h0);

    // Timeout discards a partial word.
    issued.delete(); ferr_count = 0;
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(TMO, 1'b0);
    chk("timeout_ferr_count", ferr_count, 32'd1);
    chk("timeout_no_issue", issued.size(), 32'd0);
    send_word(32'h00000002, 1'b0);
    idle(2, 1'b0);
    chk("after_timeout_count", issued.size(), 32'd1);
    if (issued.size() == 1) chk("after_timeout_word", issued[0], 32'h00000002);

    // Byte arriving on the timeout cycle wins.
    issued.delete(); ferr_count = 0;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    idle(TMO - 1, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0, 1'b0);
    cycle(1'b1, 8'hDD, 1'b0, 1'b0);
    if (NB == 5) cycle(1'b1, 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("edge_byte_no_ferr", ferr_count, 32'd0);
    chk("edge_byte_count", issued.size(), 32'd1);
    if (issued.size() == 1) chk("edge_byte_word", issued[0], 32'hDDCCBBAA);

    // Reset mid-word with queued words and a strobe in flight.
    for (int i = 0; i < 3; i++) send_word(32'h55550000 + 32'(i), 1'b1);
    cycle(1'b1, 8'h11, 1'b1, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    chk("pre_reset_ready", {31'h0, instruction_ready}, 32'h1);
    #3;
    assert_reset();
    issued.delete();
    idle(5, 1'b0);
    chk("post_reset_no_issue", issued.size(), 32'd0);
    send_word(32'h44332211, 1'b0);
    idle(2, 1'b0);
    chk("post_reset_count", issued.size(), 32'd1);
    if (issued.size() == 1) chk("post_reset_word", issued[0], 32'h44332211);

`ifdef INSTRUCTION_PACKER_CHECKSUM_EN
    issued.delete(); ferr_count = 0;
    cycle(1'b1, 8'h06, 1'b0, 1'b0); cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0); cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h06, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("csum_good_count", issued.size(), 32'd1);
    if (issued.size() == 1) chk("csum_good_word", issued[0], 32'h00000006);
    issued.delete();
    cycle(1'b1, 8'h06, 1'b0, 1'b0); cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0); cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("csum_bad_ferr", ferr_count, 32'd1);
    chk("csum_bad_no_issue", issued.size(), 32'd0);
`endif

    // Random traffic: random bytes, gaps around the timeout, hold and clears.
    for (int n = 0; n < 300; n++) begin
      int gsel;
      w = $urandom();
      for (int i = 0; i < NB; i++) begin
        logic [7:0] b;
        b = (i < 4) ? w[8*i +: 8] : (w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
        if (i == 4 && $urandom_range(0, 9) == 0) b = ~b;
        gsel = $urandom_range(0, 19);
        if (gsel == 0)      idle(TMO - 1, $urandom_range(0, 2) == 0);
        else if (gsel == 1) idle(TMO, $urandom_range(0, 2) == 0);
        else if (gsel < 6)  idle($urandom_range(1, 3), $urandom_range(0, 2) == 0);
        cycle(1'b1, b, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end
    end
    idle(TMO + DEPTH + 4, 1'b0);
    chk("final_level", {28'h0, fifo_level}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
